// File: rtl/trap_seq_ctrl.sv
// ============================================================================
// trap_seq_ctrl : machine-mode trap/return sequencer driving the CSR port
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module trap_seq_ctrl #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] CAUSE_IRQ     = 32'h8000000B,
  parameter logic [XLEN-1:0] CAUSE_ILLEGAL = 32'h2,
  parameter logic [XLEN-1:0] CAUSE_EBREAK  = 32'h3,
  parameter logic [XLEN-1:0] CAUSE_ECALL   = 32'hB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] pc,
  input  logic            is_ecall,
  input  logic            is_ebreak,
  input  logic            is_mret,
  input  logic            is_illegal,
  input  logic            irq,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_wen,
  output logic            csr_ren,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [11:0]     c_MSTATUS    = 12'h300;
  localparam logic [11:0]     c_MTVEC      = 12'h305;
  localparam logic [11:0]     c_MEPC       = 12'h341;
  localparam logic [11:0]     c_MCAUSE     = 12'h342;
  localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_STATUS = 3'd1,
    S_WR_EPC    = 3'd2,
    S_WR_CAUSE  = 3'd3,
    S_WR_STATUS = 3'd4,
    S_RD_TARGET = 3'd5,
    S_REDIRECT  = 3'd6
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_status;
  logic [XLEN-1:0] r_target;
  logic            r_is_mret;
  logic            r_is_irq;
  logic            r_irq_skip;

  logic            w_take_irq;
  logic            w_accept;
  logic [XLEN-1:0] w_cause;

  function automatic logic [XLEN-1:0] f_trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] f_mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // An interrupt that was just refused (MIE=0) lets the blocked instruction through once.
  always_comb begin
    w_take_irq = irq && !r_irq_skip;
    w_accept   = (r_state == S_IDLE) && inst_valid &&
                 (w_take_irq || is_illegal || is_ebreak || is_ecall || is_mret);
    if (w_take_irq)      w_cause = CAUSE_IRQ;
    else if (is_illegal) w_cause = CAUSE_ILLEGAL;
    else if (is_ebreak)  w_cause = CAUSE_EBREAK;
    else if (is_ecall)   w_cause = CAUSE_ECALL;
    else                 w_cause = '0;
  end

  assign stall       = (r_state != S_IDLE) || w_accept;
  assign redirect_pc = r_target;

  // CSR-port outputs are registered one state ahead so each state presents its access directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_epc          <= '0;
      r_cause        <= '0;
      r_status       <= '0;
      r_target       <= '0;
      r_is_mret      <= 1'b0;
      r_is_irq       <= 1'b0;
      r_irq_skip     <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_wen        <= 1'b0;
      csr_ren        <= 1'b0;
      redirect_valid <= 1'b0;
    end else begin
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_wen        <= 1'b0;
      csr_ren        <= 1'b0;
      redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (inst_valid) begin
            if (!w_take_irq) r_irq_skip <= 1'b0;
            if (w_accept) begin
              r_epc     <= pc;
              r_cause   <= w_cause;
              r_is_irq  <= w_take_irq;
              r_is_mret <= !w_take_irq && !is_illegal && !is_ebreak && !is_ecall;
              r_state   <= S_RD_STATUS;
              csr_ren   <= 1'b1;
              csr_addr  <= c_MSTATUS;
            end
          end
        end
        S_RD_STATUS: begin
          r_status <= csr_rdata;
          if (r_is_irq && !csr_rdata[3]) begin
            r_irq_skip <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_is_mret) begin
            r_state   <= S_WR_STATUS;
            csr_wen   <= 1'b1;
            csr_addr  <= c_MSTATUS;
            csr_wdata <= f_mret_status(csr_rdata);
          end else begin
            r_state   <= S_WR_EPC;
            csr_wen   <= 1'b1;
            csr_addr  <= c_MEPC;
            csr_wdata <= r_epc & c_ALIGN_MASK;
          end
        end
        S_WR_EPC: begin
          r_state   <= S_WR_CAUSE;
          csr_wen   <= 1'b1;
          csr_addr  <= c_MCAUSE;
          csr_wdata <= r_cause;
        end
        S_WR_CAUSE: begin
          r_state   <= S_WR_STATUS;
          csr_wen   <= 1'b1;
          csr_addr  <= c_MSTATUS;
          csr_wdata <= f_trap_status(r_status);
        end
        S_WR_STATUS: begin
          r_state  <= S_RD_TARGET;
          csr_ren  <= 1'b1;
          csr_addr <= r_is_mret ? c_MEPC : c_MTVEC;
        end
        S_RD_TARGET: begin
          r_target       <= csr_rdata & c_ALIGN_MASK;
          r_state        <= S_REDIRECT;
          redirect_valid <= 1'b1;
        end
        S_REDIRECT: begin
          r_irq_skip <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_seq_ctrl.sv
// ============================================================================
// tb_trap_seq_ctrl : directed self-checking bench with a small CSR file model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_trap_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        is_ecall, is_ebreak, is_mret, is_illegal, irq;
  logic [31:0] csr_rdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen, csr_ren, stall, redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] mstatus, mtvec, mepc, mcause;
  int n_wr_status, n_wr_epc, n_wr_cause, n_rd_status, n_both;
  int stall_cnt, redir_cnt, redir_cyc;
  logic [31:0] redir_pc;
  int tests, fails;

  trap_seq_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .is_illegal(is_illegal), .irq(irq), .csr_rdata(csr_rdata),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_ren(csr_ren), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    csr_rdata = 32'h0;
    if (csr_ren) begin
      case (csr_addr)
        12'h300: csr_rdata = mstatus;
        12'h305: csr_rdata = mtvec;
        12'h341: csr_rdata = mepc;
        12'h342: csr_rdata = mcause;
        default: csr_rdata = 32'h0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // CSR file commits writes at the negedge; then advance to just after the next posedge.
  task automatic step();
    @(negedge clk);
    if (csr_wen && csr_ren) n_both++;
    if (csr_ren && csr_addr == 12'h300) n_rd_status++;
    if (csr_wen) begin
      case (csr_addr)
        12'h300: begin mstatus = csr_wdata; n_wr_status++; end
        12'h341: begin mepc    = csr_wdata; n_wr_epc++;    end
        12'h342: begin mcause  = csr_wdata; n_wr_cause++;  end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_wr_status = 0; n_wr_epc = 0; n_wr_cause = 0; n_rd_status = 0; n_both = 0;
    stall_cnt = 0; redir_cnt = 0; redir_cyc = -1; redir_pc = 32'h0;
  endtask

  // ev = {irq, is_illegal, is_ebreak, is_ecall, is_mret}, presented for one cycle only
  task automatic run_event(input logic [31:0] pc_v, input logic [4:0] ev, input int ncyc);
    clear_counts();
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) begin
        inst_valid = 1'b1; pc = pc_v;
        {irq, is_illegal, is_ebreak, is_ecall, is_mret} = ev;
      end else begin
        inst_valid = 1'b0;
        {irq, is_illegal, is_ebreak, is_ecall, is_mret} = 5'b0;
      end
      #1;
      if (stall) stall_cnt++;
      if (redirect_valid) begin
        redir_cnt++; redir_cyc = c; redir_pc = redirect_pc;
      end
      step();
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; inst_valid = 1'b0; pc = 32'h0;
    {irq, is_illegal, is_ebreak, is_ecall, is_mret} = 5'b0;
    mstatus = 32'h0; mtvec = 32'h0; mepc = 32'h0; mcause = 32'h0;
    clear_counts();
    step(); step();
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_wen_ren", {30'b0, csr_wen, csr_ren}, 32'h0);
    check("rst_redir", {31'b0, redirect_valid}, 32'h0);
    check("rst_redir_pc", redirect_pc, 32'h0);
    check("rst_addr", {20'b0, csr_addr}, 32'h0);
    rst = 1'b0;
    step();

    // ecall trap
    mtvec = 32'h80000201; mstatus = 32'h1808;
    run_event(32'h80000104, 5'b00010, 9);
    check("ecall_mepc", mepc, 32'h80000104);
    check("ecall_mcause", mcause, 32'hB);
    check("ecall_mstatus", mstatus, 32'h1880);
    check("ecall_redir_pc", redir_pc, 32'h80000200);
    check("ecall_redir_cyc", redir_cyc, 32'd6);
    check("ecall_redir_cnt", redir_cnt, 32'd1);
    check("ecall_stall_cnt", stall_cnt, 32'd7);
    check("ecall_writes", {n_wr_epc[7:0], n_wr_cause[7:0], n_wr_status[7:0], n_rd_status[7:0]}, 32'h01010101);
    check("ecall_wen_ren_overlap", n_both, 32'd0);

    // mret
    mepc = 32'h80000108; mstatus = 32'h1880;
    run_event(32'h80000200, 5'b00001, 7);
    check("mret_mstatus", mstatus, 32'h1888);
    check("mret_redir_pc", redir_pc, 32'h80000108);
    check("mret_redir_cyc", redir_cyc, 32'd4);
    check("mret_stall_cnt", stall_cnt, 32'd5);
    check("mret_no_epc_cause_wr", n_wr_epc + n_wr_cause, 32'd0);
    check("mret_status_wr", n_wr_status, 32'd1);

    // irq and ecall together with MIE=1; misaligned pc is word-aligned in mepc
    mstatus = 32'h1808;
    run_event(32'h80000302, 5'b10010, 9);
    check("irq_mcause", mcause, 32'h8000000B);
    check("irq_mepc", mepc, 32'h80000300);
    check("irq_redir_pc", redir_pc, 32'h80000200);
    check("irq_redir_cyc", redir_cyc, 32'd6);

    // illegal beats ebreak
    mstatus = 32'h1808;
    run_event(32'h80000400, 5'b01100, 9);
    check("illegal_mcause", mcause, 32'h2);
    check("illegal_mepc", mepc, 32'h80000400);

    // ebreak beats ecall
    mstatus = 32'h1808;
    run_event(32'h80000404, 5'b00110, 9);
    check("ebreak_mcause", mcause, 32'h3);

    // irq with MIE=0: abort, blocked instruction proceeds once, then irq retriggers
    mstatus = 32'h1800; mcause = 32'h0; mepc = 32'h0;
    clear_counts();
    inst_valid = 1'b1; irq = 1'b1; pc = 32'h80000500;
    #1; check("abort_stall_c0", {31'b0, stall}, 32'h1);
    step();
    #1; check("abort_stall_c1", {31'b0, stall}, 32'h1);
    check("abort_rd_status", {20'b0, csr_addr}, 32'h300);
    pc = 32'h80000504;
    step();
    #1; check("abort_stall_c2", {31'b0, stall}, 32'h0);
    check("abort_csr_idle", {30'b0, csr_wen, csr_ren}, 32'h0);
    pc = 32'h80000508;
    step();
    #1; check("abort_retrigger_c3", {31'b0, stall}, 32'h1);
    check("abort_rd_count", n_rd_status, 32'd1);
    check("abort_wr_count", n_wr_status + n_wr_epc + n_wr_cause, 32'd0);
    inst_valid = 1'b0; irq = 1'b0;
    step(); step(); step();
    check("abort_no_redir", {31'b0, redirect_valid}, 32'h0);
    check("abort_mcause", mcause, 32'h0);
    check("abort_mstatus", mstatus, 32'h1800);

    // asynchronous reset during WR_CAUSE
    mstatus = 32'h1808; mcause = 32'h0; mepc = 32'h0;
    clear_counts();
    inst_valid = 1'b1; is_ecall = 1'b1; pc = 32'h80000600;
    step();
    inst_valid = 1'b0; is_ecall = 1'b0;
    step(); step();
    check("rstmid_in_wr_cause", {19'b0, csr_wen, csr_addr}, 32'h1342);
    #2; rst = 1'b1; #1;
    check("rstmid_stall", {31'b0, stall}, 32'h0);
    check("rstmid_wen", {31'b0, csr_wen}, 32'h0);
    check("rstmid_redir", {31'b0, redirect_valid}, 32'h0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (redirect_valid) redir_cnt++;
      step();
    end
    check("rstmid_mepc", mepc, 32'h80000600);
    check("rstmid_mcause", mcause, 32'h0);
    check("rstmid_mstatus", mstatus, 32'h1808);
    check("rstmid_no_redir", redir_cnt, 32'd0);

    // back-to-back: a new trap right after a completed one still sequences normally
    mstatus = 32'h1808;
    run_event(32'h80000700, 5'b00010, 9);
    check("b2b_mepc", mepc, 32'h80000700);
    check("b2b_redir_cyc", redir_cyc, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
